// File: rtl/dds_lut_loader.sv
// -----------------------------------------------------------------------------
// dds_lut_loader
//
// Double-buffered waveform lookup table placed in front of the AM/FM
// modulators and the wave generator. The host streams samples in as bytes
// (LSB first) with a valid/ready handshake; they land in the bank that is not
// being served. The modulator reads the active bank with one cycle of latency.
// Once a full table has been written, the banks swap on the next phase wrap of
// the modulator address, so a table is never served while half-written.
//
// Parameters
//   _RAM_ADD_WIDTH : table address width (depth = 2**_RAM_ADD_WIDTH per bank)
//   _RAM_DAT_WIDTH : sample width, one of 8/16/24/32
//
// Ports
//   i_clk          : clock
//   i_reset        : asynchronous active-low reset
//   i_start        : one-cycle pulse, begins or restarts a table load
//   i_byte         : host data byte
//   i_byte_valid   : i_byte is valid
//   o_byte_ready   : byte accepted this cycle when valid && ready
//   o_busy         : load in progress or waiting for the swap
//   o_load_done    : one-cycle pulse following a bank swap
//   o_active_bank  : bank currently served to the modulator
//   i_ram_address  : modulator read address
//   o_ram_data     : read data, one cycle after the address
// -----------------------------------------------------------------------------
module dds_lut_loader #(
  parameter int _RAM_ADD_WIDTH = 10,
  parameter int _RAM_DAT_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [7:0]                i_byte,
  input  logic                      i_byte_valid,
  output logic                      o_byte_ready,
  output logic                      o_busy,
  output logic                      o_load_done,
  output logic                      o_active_bank,
  input  logic [_RAM_ADD_WIDTH-1:0] i_ram_address,
  output logic [_RAM_DAT_WIDTH-1:0] o_ram_data
);

  localparam int AW    = _RAM_ADD_WIDTH;
  localparam int DW    = _RAM_DAT_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int BPS   = DW / 8;
  localparam int CW    = (BPS > 1) ? $clog2(BPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [AW-1:0]   wa_r;
  logic [CW-1:0]   byte_cnt_r;
  logic [DW-1:0]   asm_r;
  logic [DW-1:0]   sample_s;
  logic [AW-1:0]   prev_addr_r;
  logic            active_r;
  logic            load_done_r;
  logic [DW-1:0]   rd_data_r;

  logic            xfer_s;
  logic            last_byte_s;
  logic            wa_last_s;
  logic            wr_en_s;
  logic            wrap_s;
  logic            swap_s;
  logic            sel_s;

  logic [DW-1:0]   bank0_r [DEPTH];
  logic [DW-1:0]   bank1_r [DEPTH];

  // Handshake and event decode. A byte arriving with i_start is dropped.
  assign xfer_s      = (state_r == ST_LOAD) && i_byte_valid && !i_start;
  assign last_byte_s = (byte_cnt_r == CW'(BPS - 1));
  assign wa_last_s   = (wa_r == {AW{1'b1}});
  assign wr_en_s     = xfer_s && last_byte_s;
  assign wrap_s      = (i_ram_address < prev_addr_r);
  // A restart pulse overrides a coincident wrap: no swap in that cycle.
  assign swap_s      = (state_r == ST_WAIT_SWAP) && wrap_s && !i_start;
  // Read the new table already in the wrap cycle so there is no bubble.
  assign sel_s       = active_r ^ swap_s;

  assign o_byte_ready  = (state_r == ST_LOAD);
  assign o_busy        = (state_r != ST_IDLE);
  assign o_load_done   = load_done_r;
  assign o_active_bank = active_r;
  assign o_ram_data    = rd_data_r;

  // Merge the incoming byte into the partially assembled sample.
  always_comb begin
    sample_s = asm_r;
    for (int b = 0; b < BPS; b++) begin
      if (byte_cnt_r == CW'(b)) begin
        sample_s[b*8 +: 8] = i_byte;
      end else begin
        sample_s[b*8 +: 8] = asm_r[b*8 +: 8];
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (i_start) begin
          state_nxt_s = ST_LOAD;
        end else if (wr_en_s && wa_last_s) begin
          state_nxt_s = ST_WAIT_SWAP;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_WAIT_SWAP: begin
        if (i_start) begin
          state_nxt_s = ST_LOAD;
        end else if (wrap_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_SWAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Write address, byte counter and sample assembly.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wa_r       <= {AW{1'b0}};
      byte_cnt_r <= {CW{1'b0}};
      asm_r      <= {DW{1'b0}};
    end else if (i_start) begin
      wa_r       <= {AW{1'b0}};
      byte_cnt_r <= {CW{1'b0}};
    end else if (xfer_s) begin
      asm_r <= sample_s;
      if (last_byte_s) begin
        byte_cnt_r <= {CW{1'b0}};
        wa_r       <= wa_r + AW'(1);
      end else begin
        byte_cnt_r <= byte_cnt_r + CW'(1);
      end
    end
  end

  // Bank select, done pulse and wrap detector history.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      active_r    <= 1'b0;
      load_done_r <= 1'b0;
      prev_addr_r <= {AW{1'b0}};
    end else begin
      active_r    <= active_r ^ swap_s;
      load_done_r <= swap_s;
      prev_addr_r <= i_ram_address;
    end
  end

  // Table storage: completed samples go to the bank not being served.
  always_ff @(posedge i_clk) begin
    if (wr_en_s && !active_r) begin
      bank1_r[wa_r] <= sample_s;
    end
    if (wr_en_s && active_r) begin
      bank0_r[wa_r] <= sample_s;
    end
  end

  // Registered read port.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_data_r <= {DW{1'b0}};
    end else if (sel_s) begin
      rd_data_r <= bank1_r[i_ram_address];
    end else begin
      rd_data_r <= bank0_r[i_ram_address];
    end
  end

endmodule

// File: tb/tb_dds_lut_loader.sv
// -----------------------------------------------------------------------------
// tb_dds_lut_loader : directed bench for dds_lut_loader with an 8-entry,
// 16-bit table. Inputs change 1 ns after the rising edge; outputs are checked
// in the same window, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_dds_lut_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_d;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        load_done;
  logic        active_bank;
  logic [2:0]  ram_address;
  logic [15:0] ram_data;

  int vec_count;
  int miss_count;

  dds_lut_loader #(
    ._RAM_ADD_WIDTH(3),
    ._RAM_DAT_WIDTH(16)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_start      (start),
    .i_byte       (byte_d),
    .i_byte_valid (byte_valid),
    .o_byte_ready (byte_ready),
    .o_busy       (busy),
    .o_load_done  (load_done),
    .o_active_bank(active_bank),
    .i_ram_address(ram_address),
    .o_ram_data   (ram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    assert (obs === exp) else begin
      miss_count++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      byte_valid = 1'b0;
      byte_d     = 8'hEE;
      tick();
    end
    byte_d     = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [15:0] s, input int max_gap);
    send_byte(s[7:0],  (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    send_byte(s[15:8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    vec_count   = 0;
    miss_count  = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    byte_d      = 8'h00;
    byte_valid  = 1'b0;
    ram_address = 3'd0;
    tick();
    tick();
    chk("rst_ready",  {31'd0, byte_ready},  32'd0);
    chk("rst_busy",   {31'd0, busy},        32'd0);
    chk("rst_done",   {31'd0, load_done},   32'd0);
    chk("rst_active", {31'd0, active_bank}, 32'd0);
    chk("rst_data",   {16'd0, ram_data},    32'd0);
    rst_n = 1'b1;
    tick();

    // ---- Load A at full rate into bank 1: sample s = 0x00(s+1)
    pulse_start();
    chk("a_ready_up", {31'd0, byte_ready}, 32'd1);
    chk("a_busy_up",  {31'd0, busy},       32'd1);
    for (int s = 0; s < 8; s++) begin
      send_sample(16'(s + 1), 0);
    end
    chk("a_ready_low", {31'd0, byte_ready},  32'd0);
    chk("a_busy_wait", {31'd0, busy},        32'd1);
    chk("a_active0",   {31'd0, active_bank}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      ram_address = 3'(a);
      tick();
      chk("a_sweep_nodone", {31'd0, load_done}, 32'd0);
    end
    ram_address = 3'd0;
    tick();
    chk("a_done",    {31'd0, load_done},   32'd1);
    chk("a_active1", {31'd0, active_bank}, 32'd1);
    chk("a_rd0",     {16'd0, ram_data},    32'h0001);
    ram_address = 3'd5;
    tick();
    chk("a_done_once", {31'd0, load_done}, 32'd0);
    chk("a_rd5",       {16'd0, ram_data},  32'h0006);
    chk("a_idle",      {31'd0, busy},      32'd0);

    // ---- Load B with valid gaps into bank 0: sample s = {C0|s, 50|s}
    pulse_start();
    for (int s = 0; s < 8; s++) begin
      send_sample({8'hC0 | 8'(s), 8'h50 | 8'(s)}, 2);
    end
    chk("b_ready_low", {31'd0, byte_ready},  32'd0);
    chk("b_active1",   {31'd0, active_bank}, 32'd1);
    ram_address = 3'd3;  // 5 -> 3 is a wrap
    tick();
    chk("b_done",    {31'd0, load_done},   32'd1);
    chk("b_active0", {31'd0, active_bank}, 32'd0);
    chk("b_rd3",     {16'd0, ram_data},    32'hC353);
    ram_address = 3'd7;
    tick();
    chk("b_rd7", {16'd0, ram_data}, 32'hC757);
    chk("b_rd7_done", {31'd0, load_done}, 32'd0);

    // ---- Restart after 7 samples; wraps during LOAD are ignored
    pulse_start();
    ram_address = 3'd2;  // 7 -> 2 while loading
    for (int s = 0; s < 7; s++) begin
      send_sample({8'h77, 8'(s)}, 0);
    end
    chk("r_active_hold", {31'd0, active_bank}, 32'd0);
    chk("r_rd_old",      {16'd0, ram_data},    32'hC252);
    // Restart with a byte presented in the same cycle; it must be dropped.
    start      = 1'b1;
    byte_d     = 8'hFF;
    byte_valid = 1'b1;
    tick();
    start      = 1'b0;
    byte_valid = 1'b0;
    chk("r_ready_restart", {31'd0, byte_ready}, 32'd1);
    for (int s = 0; s < 8; s++) begin
      send_sample({8'h3C, 8'h20 + 8'(s)}, 0);
    end
    chk("r_wait", {31'd0, byte_ready}, 32'd0);
    // Stalled and rising addresses are not wraps.
    ram_address = 3'd4;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("r_hold_nodone", {31'd0, load_done}, 32'd0);
    end
    chk("r_hold_active", {31'd0, active_bank}, 32'd0);
    chk("r_hold_rd_old", {16'd0, ram_data},    32'hC454);
    ram_address = 3'd5;
    tick();
    chk("r_step_nodone", {31'd0, load_done},   32'd0);
    chk("r_step_active", {31'd0, active_bank}, 32'd0);
    chk("r_step_busy",   {31'd0, busy},        32'd1);
    ram_address = 3'd2;
    tick();
    chk("r_done",    {31'd0, load_done},   32'd1);
    chk("r_active1", {31'd0, active_bank}, 32'd1);
    chk("r_rd2",     {16'd0, ram_data},    32'h3C22);
    ram_address = 3'd6;
    tick();
    chk("r_rd6", {16'd0, ram_data}, 32'h3C26);
    ram_address = 3'd0;
    tick();
    chk("r_rd0_overwritten", {16'd0, ram_data}, 32'h3C20);

    // ---- Start coincident with wrap in WAIT_SWAP
    pulse_start();
    for (int s = 0; s < 8; s++) begin
      send_sample({8'h5A, 8'(s)}, 0);
    end
    ram_address = 3'd6;
    tick();
    chk("sw_pre_busy", {31'd0, busy}, 32'd1);
    ram_address = 3'd1;  // 6 -> 1 wrap, together with start
    start       = 1'b1;
    tick();
    start = 1'b0;
    chk("sw_active", {31'd0, active_bank}, 32'd1);
    chk("sw_done",   {31'd0, load_done},   32'd0);
    chk("sw_load",   {31'd0, byte_ready},  32'd1);
    tick();
    chk("sw_done_next",   {31'd0, load_done},   32'd0);
    chk("sw_active_next", {31'd0, active_bank}, 32'd1);

    // ---- Asynchronous reset in the middle of a load
    send_sample(16'h1234, 0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_ready",  {31'd0, byte_ready},  32'd0);
    chk("arst_busy",   {31'd0, busy},        32'd0);
    chk("arst_done",   {31'd0, load_done},   32'd0);
    chk("arst_active", {31'd0, active_bank}, 32'd0);
    chk("arst_data",   {16'd0, ram_data},    32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
